store_buffer: RTL and testbench

- Small FIFO of pending stores, placed between the core's execute/memory stage and the data memory write port.
- Accepts stores in one cycle and drains them to data memory one per cycle whenever the port is not claimed by a load.
- Loads probe the buffer. Word-aligned SW hits are forwarded with load extension applied. Any other hit stalls the load until the conflicting store drains.

---
 rtl/store_buffer_if.sv | 45 ++++
 rtl/store_buffer.sv | 153 +++++++++++++++
 tb/tb_store_buffer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: core store requests, load probe, and data-memory write port.
// The slave modport is the buffer's view; the master modport is the core/memory side.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_address;
    logic [DATA_W-1:0] st_write_data;
    logic [2:0]        st_fun3;

    logic              ld_en;
    logic [ADDR_W-1:0] ld_address;
    logic [2:0]        ld_fun3;
    logic              ld_fwd_hit;
    logic [DATA_W-1:0] ld_fwd_data;
    logic              ld_stall;

    logic              mem_busy;
    logic              mem_wd_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [2:0]        mem_fun3;

    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  st_valid, st_address, st_write_data, st_fun3,
        input  ld_en, ld_address, ld_fun3, mem_busy,
        output st_ready, ld_fwd_hit, ld_fwd_data, ld_stall,
        output mem_wd_en, mem_address, mem_write_data, mem_fun3, empty, count
    );

    modport master (
        output st_valid, st_address, st_write_data, st_fun3,
        output ld_en, ld_address, ld_fun3, mem_busy,
        input  st_ready, ld_fwd_hit, ld_fwd_data, ld_stall,
        input  mem_wd_en, mem_address, mem_write_data, mem_fun3, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer draining to the data-memory write port, with load probe.
// Define STB_FWD_EN to forward word stores to loads; otherwise any address hit stalls.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                       input logic [2:0] f3);
        logic [DATA_W-1:0] r;
        case (f3)
            F3_LB:   r = {{(DATA_W-8){d[7]}}, d[7:0]};
            F3_LH:   r = {{(DATA_W-16){d[15]}}, d[15:0]};
            F3_LW:   r = d;
            F3_LBU:  r = {{(DATA_W-8){1'b0}}, d[7:0]};
            F3_LHU:  r = {{(DATA_W-16){1'b0}}, d[15:0]};
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [2:0]        fun3_q [DEPTH];
    logic [2:0]        fun3_d [DEPTH];

    logic              st_ready_s, empty_s, mem_wd_en_s, push_s, pop_s;
    logic              match_s, fwd_hit_s, stall_s;
    logic [PTR_W-1:0]  idx_s;
    logic [DATA_W-1:0] fwd_data_s;
`ifdef STB_FWD_EN
    logic              match_sw_s;
    logic [DATA_W-1:0] match_data_s;
`endif

    assign st_ready_s  = (count_q < CNT_W'(DEPTH));
    assign empty_s     = (count_q == '0);
    assign mem_wd_en_s = !empty_s && !sb.mem_busy && !rst;
    assign push_s      = sb.st_valid && st_ready_s;
    assign pop_s       = mem_wd_en_s;

    // Next-state for pointers, occupancy and entry storage.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fun3_d  = fun3_q;
        if (push_s) begin
            addr_d[tail_q] = sb.st_address;
            data_d[tail_q] = sb.st_write_data;
            fun3_d[tail_q] = sb.st_fun3;
            tail_d         = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Load probe: walk oldest to youngest so the last held match wins.
    always_comb begin
        match_s = 1'b0;
        idx_s   = head_q;
`ifdef STB_FWD_EN
        match_sw_s   = 1'b0;
        match_data_s = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx_s] == sb.ld_address)) begin
                match_s = 1'b1;
`ifdef STB_FWD_EN
                match_sw_s   = (fun3_q[idx_s] == F3_SW);
                match_data_s = data_q[idx_s];
`endif
            end else begin
                match_s = match_s;
            end
        end
    end

    // Forward / stall decision for the probing load.
    always_comb begin
`ifdef STB_FWD_EN
        fwd_hit_s  = sb.ld_en && match_s && match_sw_s;
        stall_s    = sb.ld_en && match_s && !match_sw_s;
        fwd_data_s = fwd_hit_s ? load_extend(match_data_s, sb.ld_fun3) : '0;
`else
        fwd_hit_s  = 1'b0;
        stall_s    = sb.ld_en && match_s;
        fwd_data_s = '0;
`endif
    end

    // Pointer and occupancy state; reset discards all pending stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed below count, so no reset is needed.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        fun3_q <= fun3_d;
    end

    assign sb.st_ready       = st_ready_s;
    assign sb.empty          = empty_s;
    assign sb.count          = count_q;
    assign sb.mem_wd_en      = mem_wd_en_s;
    assign sb.mem_address    = empty_s ? '0 : addr_q[head_q];
    assign sb.mem_write_data = empty_s ? '0 : data_q[head_q];
    assign sb.mem_fun3       = empty_s ? 3'b000 : fun3_q[head_q];
    assign sb.ld_fwd_hit     = fwd_hit_s;
    assign sb.ld_fwd_data    = fwd_data_s;
    assign sb.ld_stall       = stall_s;
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain order, full/backpressure,
// forwarding or stalling on load hits, reset discard, and pointer wrap.
module tb_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

`ifdef STB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Memory model: a write commits on every edge where the enable is high.
    always @(posedge clk) begin
        if (sb.mem_wd_en === 1'b1) begin
            wr_addr.push_back(sb.mem_address);
            wr_data.push_back(sb.mem_write_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        sb.st_valid      = 1'b1;
        sb.st_address    = a;
        sb.st_write_data = d;
        sb.st_fun3       = f3;
        tick();
        sb.st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int guard = 0;
        while (sb.empty !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk(tag, {63'd0, guard < 50}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int guard;
        int n_before;
        logic rdy;

        rst = 1'b1;
        sb.st_valid = 1'b0; sb.st_address = '0; sb.st_write_data = '0; sb.st_fun3 = 3'b000;
        sb.ld_en = 1'b0; sb.ld_address = '0; sb.ld_fun3 = 3'b000; sb.mem_busy = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wd_en", {63'd0, sb.mem_wd_en}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", {63'd0, sb.empty}, 64'd1);
        chk("rst_count", {61'd0, sb.count}, 64'd0);
        chk("rst_ready", {63'd0, sb.st_ready}, 64'd1);
        chk("rst_wd_en2", {63'd0, sb.mem_wd_en}, 64'd0);
        chk("rst_fwd_stall", {62'd0, sb.ld_fwd_hit, sb.ld_stall}, 64'd0);
        chk("rst_data", {sb.mem_address, sb.mem_write_data}, 64'd0);
        chk("rst_fun3_fwd", {29'd0, sb.mem_fun3, sb.ld_fwd_data}, 64'd0);
        tick();

        // Single SW: visible on the memory port the next cycle, then drained.
        push_store(32'd5, 32'hDEADBEEF, 3'b010);
        @(negedge clk);
        chk("t1_wd_en", {63'd0, sb.mem_wd_en}, 64'd1);
        chk("t1_addr", {32'd0, sb.mem_address}, 64'd5);
        chk("t1_data", {32'd0, sb.mem_write_data}, 64'hDEADBEEF);
        chk("t1_fun3", {61'd0, sb.mem_fun3}, 64'd2);
        tick();
        @(negedge clk);
        chk("t1_empty", {63'd0, sb.empty}, 64'd1);
        tick();

        // Fill while memory busy; fifth store refused; in-order drain.
        sb.mem_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push_store(32'(i), 32'h100 + 32'(i), 3'b010);
        @(negedge clk);
        chk("t2_count", {61'd0, sb.count}, 64'd4);
        chk("t2_ready", {63'd0, sb.st_ready}, 64'd0);
        chk("t2_no_drain", {63'd0, sb.mem_wd_en}, 64'd0);
        push_store(32'd99, 32'h99, 3'b010);
        @(negedge clk);
        chk("t2_count_full", {61'd0, sb.count}, 64'd4);
        wr_addr.delete();
        wr_data.delete();
        tick();
        sb.mem_busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2_wd_en", {63'd0, sb.mem_wd_en}, 64'd1);
            chk("t2_addr", {32'd0, sb.mem_address}, 64'(i));
            tick();
        end
        @(negedge clk);
        chk("t2_empty", {63'd0, sb.empty}, 64'd1);
        chk("t2_nwrites", 64'(wr_addr.size()), 64'd4);
        tick();

        // Two SWs to the same address; youngest forwarded with extension.
        sb.mem_busy = 1'b1;
        push_store(32'd7, 32'h000000F0, 3'b010);
        push_store(32'd7, 32'h00000080, 3'b010);
        sb.ld_en = 1'b1; sb.ld_address = 32'd7; sb.ld_fun3 = 3'b000;
        @(negedge clk);
        chk("t3_lb_hit", {63'd0, sb.ld_fwd_hit}, 64'(FWD));
        chk("t3_lb_stall", {63'd0, sb.ld_stall}, 64'(!FWD));
        chk("t3_lb_data", {32'd0, sb.ld_fwd_data}, FWD ? 64'hFFFFFF80 : 64'd0);
        sb.ld_fun3 = 3'b100;
        @(negedge clk);
        chk("t3_lbu_data", {32'd0, sb.ld_fwd_data}, FWD ? 64'h00000080 : 64'd0);
        sb.ld_fun3 = 3'b001;
        @(negedge clk);
        chk("t3_lh_data", {32'd0, sb.ld_fwd_data}, FWD ? 64'h00000080 : 64'd0);
        sb.ld_address = 32'd8;
        @(negedge clk);
        chk("t3_miss", {62'd0, sb.ld_fwd_hit, sb.ld_stall}, 64'd0);
        sb.ld_address = 32'd7; sb.ld_en = 1'b0;
        @(negedge clk);
        chk("t3_ld_off", {sb.ld_fwd_data, 30'd0, sb.ld_fwd_hit, sb.ld_stall}, 64'd0);
        tick();
        sb.mem_busy = 1'b0;
        wait_empty("t3_drain_timeout");

        // Held SB stalls a load until it drains; younger SW at another address forwards.
        sb.mem_busy = 1'b1;
        push_store(32'd9, 32'h00000055, 3'b000);
        push_store(32'd12, 32'hFFFF8001, 3'b010);
        sb.ld_en = 1'b1; sb.ld_address = 32'd12; sb.ld_fun3 = 3'b001;
        @(negedge clk);
        chk("t4_lh_data", {32'd0, sb.ld_fwd_data}, FWD ? 64'hFFFF8001 : 64'd0);
        sb.ld_fun3 = 3'b101;
        @(negedge clk);
        chk("t4_lhu_data", {32'd0, sb.ld_fwd_data}, FWD ? 64'h00008001 : 64'd0);
        chk("t4_lhu_stall", {63'd0, sb.ld_stall}, 64'(!FWD));
        sb.ld_address = 32'd9; sb.ld_fun3 = 3'b010;
        @(negedge clk);
        chk("t4_sb_stall", {63'd0, sb.ld_stall}, 64'd1);
        chk("t4_sb_hit", {63'd0, sb.ld_fwd_hit}, 64'd0);
        tick();
        sb.mem_busy = 1'b0;
        @(negedge clk);
        chk("t4_head_sb", {29'd0, sb.mem_fun3, sb.mem_address}, {29'd0, 3'b000, 32'd9});
        chk("t4_stall_held", {63'd0, sb.ld_stall}, 64'd1);
        tick();
        @(negedge clk);
        chk("t4_stall_clear", {63'd0, sb.ld_stall}, 64'd0);
        chk("t4_next_head", {32'd0, sb.mem_address}, 64'd12);
        sb.ld_en = 1'b0;
        tick();
        wait_empty("t4_drain_timeout");

        // Reset mid-drain discards held stores.
        sb.mem_busy = 1'b1;
        push_store(32'd20, 32'h20, 3'b010);
        push_store(32'd21, 32'h21, 3'b010);
        push_store(32'd22, 32'h22, 3'b010);
        @(negedge clk);
        chk("t5_count", {61'd0, sb.count}, 64'd3);
        tick();
        n_before = wr_addr.size();
        sb.mem_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_wd_en_rst", {63'd0, sb.mem_wd_en}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_count_after", {61'd0, sb.count}, 64'd0);
        chk("t5_empty_after", {63'd0, sb.empty}, 64'd1);
        chk("t5_wd_en_after", {63'd0, sb.mem_wd_en}, 64'd0);
        tick();
        tick();
        chk("t5_no_writes", 64'(wr_addr.size()), 64'(n_before));

        // Full buffer streaming with drain; 3*DEPTH stores through wrapping pointers.
        sb.mem_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_store(32'd100 + 32'(i), 32'hA5000000 + 32'(i) * 32'h111, 3'b010);
        wr_addr.delete();
        wr_data.delete();
        sb.mem_busy = 1'b0;
        idx = DEPTH;
        guard = 0;
        sb.st_valid = 1'b1;
        while (idx < 3 * DEPTH && guard < 100) begin
            sb.st_address    = 32'd100 + 32'(idx);
            sb.st_write_data = 32'hA5000000 + 32'(idx) * 32'h111;
            sb.st_fun3       = 3'b010;
            @(negedge clk);
            rdy = sb.st_ready;
            if (guard == 0) begin
                chk("t6_full_ready_low", {63'd0, rdy}, 64'd0);
                chk("t6_full_draining", {63'd0, sb.mem_wd_en}, 64'd1);
            end
            tick();
            if (rdy) idx++;
            guard++;
        end
        sb.st_valid = 1'b0;
        chk("t6_push_timeout", {63'd0, guard < 100}, 64'd1);
        wait_empty("t6_drain_timeout");
        chk("t6_nwrites", 64'(wr_addr.size()), 64'(3 * DEPTH));
        for (int i = 0; i < 3 * DEPTH && i < wr_addr.size(); i++) begin
            chk("t6_addr", {32'd0, wr_addr[i]}, 64'd100 + 64'(i));
            chk("t6_data", {32'd0, wr_data[i]}, {32'd0, 32'hA5000000 + 32'(i) * 32'h111});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
